// File: rtl/avalon_ack_watchdog_if.sv
// Single-transfer Avalon-style bus between a master and a slave.
// Requests, address and data flow master->slave; read data and acknowledge flow slave->master.
interface avalon_ack_watchdog_if;
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        acknowledge;

    modport master (
        output read, write, address, byte_enable, write_data,
        input  read_data, acknowledge
    );

    modport slave (
        input  read, write, address, byte_enable, write_data,
        output read_data, acknowledge
    );
endinterface

// File: rtl/avalon_ack_watchdog.sv
// Transaction guard: forwards single Avalon accesses and forces an error ack if the slave hangs.
// Optional AVL_WATCHDOG_STATS_EN adds a saturating timeout_count output.
module avalon_ack_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_W      = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                         clk,
    input  logic                         nreset,
    avalon_ack_watchdog_if.slave         m_bus,
    avalon_ack_watchdog_if.master        s_bus,
    output logic                         timeout_err,
    output logic                         proto_err
`ifdef AVL_WATCHDOG_STATS_EN
    ,
    output logic [15:0]                  timeout_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [TIMEOUT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state               <= IDLE;
            wait_cnt            <= '0;
            s_bus.read          <= 1'b0;
            s_bus.write         <= 1'b0;
            s_bus.address       <= '0;
            s_bus.byte_enable   <= '0;
            s_bus.write_data    <= '0;
            m_bus.read_data     <= '0;
            m_bus.acknowledge   <= 1'b0;
            timeout_err         <= 1'b0;
            proto_err           <= 1'b0;
`ifdef AVL_WATCHDOG_STATS_EN
            timeout_count       <= '0;
`endif
        end else begin
            m_bus.acknowledge <= 1'b0;
            timeout_err       <= 1'b0;
            proto_err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_bus.acknowledge) begin
                        proto_err <= 1'b1;
                    end
                    if (m_bus.read && m_bus.write) begin
                        m_bus.acknowledge <= 1'b1;
                        m_bus.read_data   <= ERR_DATA;
                        proto_err         <= 1'b1;
                        state             <= DONE;
                    end else if (m_bus.read || m_bus.write) begin
                        s_bus.read        <= m_bus.read;
                        s_bus.write       <= m_bus.write;
                        s_bus.address     <= m_bus.address;
                        s_bus.byte_enable <= m_bus.byte_enable;
                        s_bus.write_data  <= m_bus.write_data;
                        wait_cnt          <= '0;
                        state             <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A real ack on the expiry cycle takes priority over the forced error.
                    if (s_bus.acknowledge) begin
                        s_bus.read        <= 1'b0;
                        s_bus.write       <= 1'b0;
                        m_bus.acknowledge <= 1'b1;
                        m_bus.read_data   <= s_bus.read ? s_bus.read_data : 32'h0;
                        state             <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        s_bus.read        <= 1'b0;
                        s_bus.write       <= 1'b0;
                        m_bus.acknowledge <= 1'b1;
                        m_bus.read_data   <= ERR_DATA;
                        timeout_err       <= 1'b1;
                        state             <= DONE;
`ifdef AVL_WATCHDOG_STATS_EN
                        if (timeout_count != 16'hFFFF) begin
                            timeout_count <= timeout_count + 16'd1;
                        end
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Waiting for the master to drop its request stops a held request re-issuing.
                    if (s_bus.acknowledge) begin
                        proto_err <= 1'b1;
                    end
                    if (!m_bus.read && !m_bus.write) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_ack_watchdog.sv
// Directed self-checking bench for avalon_ack_watchdog with TIMEOUT_CYCLES=8.
module tb_avalon_ack_watchdog;

    logic clk = 1'b0;
    logic nreset;
    logic timeout_err;
    logic proto_err;
`ifdef AVL_WATCHDOG_STATS_EN
    logic [15:0] timeout_count;
`endif

    int vector_count = 0;
    int miss_count   = 0;

    avalon_ack_watchdog_if m_bus ();
    avalon_ack_watchdog_if s_bus ();

    avalon_ack_watchdog #(
        .TIMEOUT_CYCLES (8),
        .TIMEOUT_W      (16),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .m_bus          (m_bus),
        .s_bus          (s_bus),
        .timeout_err    (timeout_err),
        .proto_err      (proto_err)
`ifdef AVL_WATCHDOG_STATS_EN
        ,
        .timeout_count  (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vector_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata);
        m_bus.read        = rd;
        m_bus.write       = wr;
        m_bus.address     = addr;
        m_bus.byte_enable = be;
        m_bus.write_data  = wdata;
    endtask

    task automatic slaveAck(input logic ack, input logic [31:0] rdata);
        s_bus.acknowledge = ack;
        s_bus.read_data   = rdata;
    endtask

    // Read that the slave never acknowledges; checks the forced error ack 8 cycles after s_read.
    task automatic runTimeout(input string tag, input logic [31:0] addr);
        applyStimulus(1'b1, 1'b0, addr, 4'hF, 32'h0);
        tick();
        checkOutput({tag, "_sread_up"}, 32'(s_bus.read), 32'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        checkOutput({tag, "_no_early_ack"}, 32'(m_bus.acknowledge), 32'd0);
        tick();
        checkOutput({tag, "_ack"}, 32'(m_bus.acknowledge), 32'd1);
        checkOutput({tag, "_terr"}, 32'(timeout_err), 32'd1);
        checkOutput({tag, "_rdata"}, m_bus.read_data, 32'hDEAD_BEEF);
        checkOutput({tag, "_sread_down"}, 32'(s_bus.read), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        checkOutput({tag, "_ack_pulse"}, 32'(m_bus.acknowledge), 32'd0);
        checkOutput({tag, "_terr_pulse"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int ack_seen;
        int strobe_seen;

        nreset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        slaveAck(1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_mack", 32'(m_bus.acknowledge), 32'd0);
        checkOutput("rst_mrdata", m_bus.read_data, 32'h0);
        checkOutput("rst_sread", 32'(s_bus.read), 32'd0);
        checkOutput("rst_swrite", 32'(s_bus.write), 32'd0);
        checkOutput("rst_terr", 32'(timeout_err), 32'd0);
        checkOutput("rst_perr", 32'(proto_err), 32'd0);
        nreset = 1'b1;
        tick();

        // Read, slave acks 3 cycles after s_read rises.
        applyStimulus(1'b1, 1'b0, 32'h40, 4'h3, 32'h0);
        tick();
        checkOutput("rd_sread", 32'(s_bus.read), 32'd1);
        checkOutput("rd_saddr", s_bus.address, 32'h40);
        checkOutput("rd_sbe", 32'(s_bus.byte_enable), 32'h3);
        tick();
        tick();
        checkOutput("rd_wait_mack", 32'(m_bus.acknowledge), 32'd0);
        slaveAck(1'b1, 32'h1234_5678);
        tick();
        slaveAck(1'b0, 32'h0);
        checkOutput("rd_mack", 32'(m_bus.acknowledge), 32'd1);
        checkOutput("rd_mrdata", m_bus.read_data, 32'h1234_5678);
        checkOutput("rd_terr", 32'(timeout_err), 32'd0);
        checkOutput("rd_sread_down", 32'(s_bus.read), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        checkOutput("rd_mack_pulse", 32'(m_bus.acknowledge), 32'd0);
        checkOutput("rd_rdata_hold", m_bus.read_data, 32'h1234_5678);

        // Write with immediate slave ack.
        applyStimulus(1'b0, 1'b1, 32'h10, 4'hF, 32'hA5A5_A5A5);
        tick();
        checkOutput("wr_swrite", 32'(s_bus.write), 32'd1);
        checkOutput("wr_sread", 32'(s_bus.read), 32'd0);
        checkOutput("wr_saddr", s_bus.address, 32'h10);
        checkOutput("wr_sbe", 32'(s_bus.byte_enable), 32'hF);
        checkOutput("wr_swdata", s_bus.write_data, 32'hA5A5_A5A5);
        slaveAck(1'b1, 32'hFFFF_FFFF);
        tick();
        slaveAck(1'b0, 32'h0);
        checkOutput("wr_mack", 32'(m_bus.acknowledge), 32'd1);
        checkOutput("wr_mrdata", m_bus.read_data, 32'h0);
        checkOutput("wr_swrite_down", 32'(s_bus.write), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        checkOutput("wr_mack_pulse", 32'(m_bus.acknowledge), 32'd0);

        // Timeout, then a late ack produces proto_err but no second master ack.
        runTimeout("to", 32'h20);
        slaveAck(1'b1, 32'h5555_5555);
        tick();
        slaveAck(1'b0, 32'h0);
        checkOutput("late_perr", 32'(proto_err), 32'd1);
        checkOutput("late_mack", 32'(m_bus.acknowledge), 32'd0);
        checkOutput("late_rdata_hold", m_bus.read_data, 32'hDEAD_BEEF);
        tick();
        checkOutput("late_perr_pulse", 32'(proto_err), 32'd0);

        // Ack arriving on the expiry cycle completes normally.
        applyStimulus(1'b1, 1'b0, 32'h30, 4'hF, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        checkOutput("exp_no_early_ack", 32'(m_bus.acknowledge), 32'd0);
        slaveAck(1'b1, 32'hCAFE_F00D);
        tick();
        slaveAck(1'b0, 32'h0);
        checkOutput("exp_mack", 32'(m_bus.acknowledge), 32'd1);
        checkOutput("exp_mrdata", m_bus.read_data, 32'hCAFE_F00D);
        checkOutput("exp_terr", 32'(timeout_err), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();

        // Read and write together, held for 5 cycles: one error ack, no slave strobe.
        applyStimulus(1'b1, 1'b1, 32'h50, 4'hF, 32'h1);
        ack_seen    = 0;
        strobe_seen = 0;
        tick();
        checkOutput("rw_mack", 32'(m_bus.acknowledge), 32'd1);
        checkOutput("rw_mrdata", m_bus.read_data, 32'hDEAD_BEEF);
        checkOutput("rw_perr", 32'(proto_err), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (s_bus.read || s_bus.write) strobe_seen++;
            if (i > 0 && m_bus.acknowledge) ack_seen++;
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        if (s_bus.read || s_bus.write) strobe_seen++;
        if (m_bus.acknowledge) ack_seen++;
        checkOutput("rw_extra_acks", 32'(ack_seen), 32'd0);
        checkOutput("rw_strobes", 32'(strobe_seen), 32'd0);
        tick();

        // Reset during ISSUE drops the strobe and never acks the master.
        applyStimulus(1'b1, 1'b0, 32'h44, 4'hF, 32'h0);
        tick();
        checkOutput("rst_issue_sread", 32'(s_bus.read), 32'd1);
        tick();
        nreset = 1'b0;
        tick();
        checkOutput("rst_issue_drop", 32'(s_bus.read), 32'd0);
        checkOutput("rst_issue_mack", 32'(m_bus.acknowledge), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        nreset = 1'b1;
        tick();
        checkOutput("rst_after_mack", 32'(m_bus.acknowledge), 32'd0);
        checkOutput("rst_after_sread", 32'(s_bus.read), 32'd0);

`ifdef AVL_WATCHDOG_STATS_EN
        checkOutput("stats_reset", 32'(timeout_count), 32'd0);
        runTimeout("st1", 32'h60);
        runTimeout("st2", 32'h64);
        runTimeout("st3", 32'h68);
        checkOutput("stats_count", 32'(timeout_count), 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
